// File: rtl/hls_srl_fifo_v2.sv
// rtl/hls_srl_fifo_v2.sv - shift-register FIFO with registered flags, flush and optional output register
// Data shifts in at SRL index 0 and is read at cnt-1; OUT_REG adds one holding stage (capacity DEPTH+1).
module hls_srl_fifo_v2 #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int AF_MARGIN  = 1,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic                  if_almost_full,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  typedef enum logic {OEMPTY = 1'b0, OVALID = 1'b1} ostate_t;

  localparam bit                  USE_OREG = (OUT_REG != 0);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  ostate_t               state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  full_n_q, empty_n_q, af_q;
  logic                  push_acc, pop_acc, load, srl_pop;
  logic [ADDR_WIDTH-1:0] raddr;

  assign raddr = (cnt_q == '0) ? '0 : ADDR_WIDTH'(cnt_q - CNT_ONE);

  // SRL storage is intentionally not reset; flush leaves it untouched too.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      srl_q[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= OEMPTY;
      cnt_q     <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      full_n_q  <= (cnt_d != CNT_FULL);
      empty_n_q <= (cnt_d != '0);
      af_q      <= (cnt_d >= CNT_AF);
      if (load) begin
        dout_q <= srl_q[raddr];
      end
    end
  end

  always_comb begin
    push_acc = if_write & full_n_q & ~flush;
    pop_acc  = 1'b0;
    load     = 1'b0;
    state_d  = state_q;
    if (USE_OREG) begin
      pop_acc = if_read & (state_q == OVALID) & ~flush;
      // Refill the output stage whenever it is empty or being drained this cycle.
      load    = ~flush & (cnt_q != '0) & ((state_q == OEMPTY) | pop_acc);
      if (flush) begin
        state_d = OEMPTY;
      end else begin
        unique case (state_q)
          OEMPTY:  if (load) state_d = OVALID;
          OVALID:  if (pop_acc && !load) state_d = OEMPTY;
          default: state_d = OEMPTY;
        endcase
      end
    end else begin
      pop_acc = if_read & empty_n_q & ~flush;
    end
    srl_pop = USE_OREG ? load : pop_acc;
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      unique case ({push_acc, srl_pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    if_full_n      = full_n_q;
    if_almost_full = af_q;
    if (USE_OREG) begin
      if_empty_n        = (state_q == OVALID);
      if_dout           = dout_q;
      if_num_data_valid = cnt_q + {{ADDR_WIDTH{1'b0}}, (state_q == OVALID)};
    end else begin
      if_empty_n        = empty_n_q;
      if_dout           = srl_q[raddr];
      if_num_data_valid = cnt_q;
    end
  end

endmodule

// File: tb/tb_hls_srl_fifo_v2.sv
// tb/tb_hls_srl_fifo_v2.sv - random and directed checks of both output modes against queue models
module tb_hls_srl_fifo_v2;

  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int DEP = 4;
  localparam int AFM = 1;
  localparam int THR = DEP - AFM;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] din = '0;

  logic          f0, e0, af0, f1, e1, af1;
  logic [DW-1:0] d0, d1;
  logic [AW:0]   n0, n1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] s1[$];
  bit            ov1 = 1'b0;
  logic [DW-1:0] ov1_val = '0;

  always #5 clk = ~clk;

  hls_srl_fifo_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .AF_MARGIN(AFM), .OUT_REG(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush),
    .if_write(wr), .if_din(din), .if_full_n(f0),
    .if_read(rd), .if_dout(d0), .if_empty_n(e0),
    .if_almost_full(af0), .if_num_data_valid(n0)
  );

  hls_srl_fifo_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .AF_MARGIN(AFM), .OUT_REG(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush),
    .if_write(wr), .if_din(din), .if_full_n(f1),
    .if_read(rd), .if_dout(d1), .if_empty_n(e1),
    .if_almost_full(af1), .if_num_data_valid(n1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    s1.delete();
    ov1 = 1'b0;
  endtask

  task automatic model_update(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    bit pu0, po0, pu1, po1;
    int old;
    if (f) begin
      model_clear();
    end else begin
      pu0 = w && (q0.size() < DEP);
      po0 = r && (q0.size() > 0);
      if (po0) void'(q0.pop_front());
      if (pu0) q0.push_back(d);
      old = s1.size();
      pu1 = w && (old < DEP);
      po1 = r && ov1;
      if (po1) ov1 = 1'b0;
      if (!ov1 && old > 0) begin
        ov1_val = s1.pop_front();
        ov1 = 1'b1;
      end
      if (pu1) s1.push_back(d);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".empty_n0"}, e0, q0.size() > 0);
    check({tag, ".full_n0"}, f0, q0.size() < DEP);
    check({tag, ".af0"}, af0, q0.size() >= THR);
    check({tag, ".num0"}, n0, q0.size());
    if (q0.size() > 0) check({tag, ".dout0"}, d0, q0[0]);
    check({tag, ".empty_n1"}, e1, ov1);
    check({tag, ".full_n1"}, f1, s1.size() < DEP);
    check({tag, ".af1"}, af1, s1.size() >= THR);
    check({tag, ".num1"}, n1, s1.size() + int'(ov1));
    if (ov1) check({tag, ".dout1"}, d1, ov1_val);
  endtask

  task automatic step(input string tag, input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    wr = w; din = d; rd = r; flush = f;
    @(posedge clk);
    model_update(w, d, r, f);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    int wp, rp;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    compare_all("rst");
    check("rst.dout1", d1, 0);
    reset = 1'b0;

    // fill: u0 takes 4, u1 takes 5
    step("fill", 1'b1, 8'hA, 1'b0, 1'b0);
    check("fill1.e0", e0, 1);
    check("fill1.e1", e1, 0);
    step("fill", 1'b1, 8'hB, 1'b0, 1'b0);
    check("fill2.e1", e1, 1);
    step("fill", 1'b1, 8'hC, 1'b0, 1'b0);
    check("fill3.af0", af0, 1);
    check("fill3.f0", f0, 1);
    step("fill", 1'b1, 8'hD, 1'b0, 1'b0);
    check("fill4.f0", f0, 0);
    step("fill", 1'b1, 8'hE, 1'b0, 1'b0);
    check("fill5.n0", n0, 4);
    check("fill5.n1", n1, 5);
    check("fill5.f1", f1, 0);

    step("wr_rd_full", 1'b1, 8'h77, 1'b1, 1'b0);
    check("wr_rd_full.n0", n0, 3);
    check("wr_rd_full.n1", n1, 4);
    repeat (6) step("drain", 1'b0, 8'h0, 1'b1, 1'b0);
    check("drain.e0", e0, 0);
    check("drain.e1", e1, 0);

    step("wr_rd_empty", 1'b1, 8'h21, 1'b1, 1'b0);
    check("wr_rd_empty.n0", n0, 1);
    check("wr_rd_empty.n1", n1, 1);
    step("idle", 1'b0, 8'h0, 1'b0, 1'b0);
    repeat (2) step("drain", 1'b0, 8'h0, 1'b1, 1'b0);

    // streaming at occupancy 2
    step("pre", 1'b1, 8'd0, 1'b0, 1'b0);
    step("pre", 1'b1, 8'd1, 1'b0, 1'b0);
    for (int i = 2; i < 102; i++) begin
      step("stream", 1'b1, DW'(i), 1'b1, 1'b0);
      check("stream.n0", n0, 2);
      check("stream.n1", n1, 2);
    end
    repeat (3) step("drain", 1'b0, 8'h0, 1'b1, 1'b0);

    // flush beats push and pop
    for (int i = 0; i < 3; i++) step("pf", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    step("pf", 1'b0, 8'h0, 1'b0, 1'b0);
    step("flush", 1'b1, 8'h99, 1'b1, 1'b1);
    check("flush.n0", n0, 0);
    check("flush.n1", n1, 0);
    check("flush.e0", e0, 0);
    check("flush.f1", f1, 1);
    step("post", 1'b1, 8'h5, 1'b0, 1'b0);
    step("post", 1'b0, 8'h0, 1'b0, 1'b0);
    check("post.d0", d0, 5);
    check("post.d1", d1, 5);
    step("post", 1'b0, 8'h0, 1'b1, 1'b0);

    // async reset between edges
    for (int i = 0; i < 3; i++) step("pa", 1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_clear();
    compare_all("areset");
    check("areset.dout1", d1, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("after_rst", 1'b1, 8'h42, 1'b0, 1'b0);
    check("after_rst.n0", n0, 1);

    // randomized traffic with shifting read/write bias
    wp = 60; rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        wp = $urandom_range(20, 90);
        rp = $urandom_range(20, 90);
      end
      step("rand", ($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 99) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
